dma_channel_sequencer: RTL

//  Multi-channel DMA transfer sequencer for the DMA controller. It arbitrates NCH DREQ lines,

---
 rtl/dma_channel_sequencer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/dma_channel_sequencer.sv
// Multi-channel DMA transfer sequencer: DREQ arbitration, HRQ/HLDA handshake,
// SI..S4 transfer sequencing, bus strobes and per-channel address/count state.
module dma_channel_sequencer #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 16,
  parameter bit          ROTATE = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cs,
  input  logic                    ld_en,
  input  logic [$clog2(NCH)-1:0]  ld_ch,
  input  logic [ADDR_W-1:0]       ld_addr,
  input  logic [CNT_W-1:0]        ld_cnt,
  input  logic                    ld_wr,
  input  logic                    ld_blk,
  input  logic [NCH-1:0]          dreq,
  input  logic                    HLDA,
  input  logic                    ready,
  output logic                    HRQ,
  output logic                    AEN,
  output logic                    ADSTB,
  output logic [NCH-1:0]          dack,
  output logic                    memread,
  output logic                    memwrite,
  output logic                    ior,
  output logic                    iow,
  output logic [ADDR_W-1:0]       addr,
  output logic                    tc,
  output logic [NCH-1:0]          mask
);

  localparam int unsigned CH_W = $clog2(NCH);

  typedef enum logic [2:0] {SI, S0, S1, S2, S3, S4} state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CH_W-1:0]   last_q, last_d;
  logic [NCH-1:0]    mask_q, mask_d;
  logic [ADDR_W-1:0] ch_addr_q [NCH];
  logic [ADDR_W-1:0] ch_addr_d [NCH];
  logic [CNT_W-1:0]  ch_cnt_q  [NCH];
  logic [CNT_W-1:0]  ch_cnt_d  [NCH];
  logic [NCH-1:0]    ch_wr_q, ch_wr_d;
  logic [NCH-1:0]    ch_blk_q, ch_blk_d;

  logic              hrq_q, hrq_d, aen_q, aen_d, adstb_q, adstb_d;
  logic              memread_q, memread_d, memwrite_q, memwrite_d;
  logic              ior_q, ior_d, iow_q, iow_d, tc_q, tc_d;
  logic [NCH-1:0]    dack_q, dack_d;

  logic [NCH-1:0]    eligible;
  logic              grant_vld;
  logic [CH_W-1:0]   grant_ch;
  logic [CH_W-1:0]   idx_v;
  int unsigned       start_v;
  logic              abort;
  logic              ld_ok;
  logic              rd_on, wr_on;

  assign eligible = dreq & ~mask_q;
  assign abort    = (state_q inside {S1, S2, S3, S4}) && !HLDA;
  assign ld_ok    = !cs && ld_en && (32'(ld_ch) < NCH) &&
                    !((state_q != SI) && (ld_ch == ch_q));

  // Priority search: from ch0 (fixed) or from the channel after the last served one (rotate)
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    idx_v     = '0;
    start_v   = ROTATE ? ((32'(last_q) + 1) % NCH) : 0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx_v = CH_W'((start_v + i) % NCH);
      if (!grant_vld && eligible[idx_v]) begin
        grant_vld = 1'b1;
        grant_ch  = idx_v;
      end
    end
  end

  // Next-state, channel bookkeeping and register-file loads
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    last_d    = last_q;
    mask_d    = mask_q;
    ch_addr_d = ch_addr_q;
    ch_cnt_d  = ch_cnt_q;
    ch_wr_d   = ch_wr_q;
    ch_blk_d  = ch_blk_q;
    if (abort) begin
      state_d = SI;
    end else begin
      case (state_q)
        SI: if (grant_vld) begin
          state_d = S0;
          ch_d    = grant_ch;
          last_d  = grant_ch;
        end
        S0: if (HLDA) state_d = S1;
        S1: state_d = S2;
        S2: state_d = S3;
        S3: if (ready) state_d = S4;
        S4: begin
          ch_addr_d[ch_q] = ch_addr_q[ch_q] + ADDR_W'(1);
          ch_cnt_d[ch_q]  = ch_cnt_q[ch_q] - CNT_W'(1);
          if (ch_cnt_q[ch_q] == '0) begin
            mask_d[ch_q] = 1'b1;
            state_d      = SI;
          end else if (ch_blk_q[ch_q]) begin
            state_d = S1;
          end else begin
            state_d = SI;
          end
        end
        default: state_d = SI;
      endcase
    end
    // Active-channel loads are blocked outside SI, which also makes TC win over a same-cycle load
    if (ld_ok) begin
      ch_addr_d[ld_ch] = ld_addr;
      ch_cnt_d[ld_ch]  = ld_cnt;
      ch_wr_d[ld_ch]   = ld_wr;
      ch_blk_d[ld_ch]  = ld_blk;
      mask_d[ld_ch]    = 1'b0;
    end
  end

  // Bus outputs decoded from the next state so they come straight from flops
  always_comb begin
    hrq_d      = (state_d != SI);
    aen_d      = (state_d inside {S1, S2, S3, S4});
    adstb_d    = (state_d == S1);
    dack_d     = '0;
    if (state_d inside {S2, S3, S4}) dack_d[ch_d] = 1'b1;
    rd_on      = (state_d inside {S2, S3});
    wr_on      = (state_d == S3);
    ior_d      = rd_on &&  ch_wr_q[ch_d];
    memread_d  = rd_on && !ch_wr_q[ch_d];
    memwrite_d = wr_on &&  ch_wr_q[ch_d];
    iow_d      = wr_on && !ch_wr_q[ch_d];
    tc_d       = (state_d == S4) && (ch_cnt_q[ch_d] == '0);
  end

  // State, channel and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= SI;
      ch_q       <= '0;
      last_q     <= CH_W'(NCH - 1);
      mask_q     <= '1;
      ch_wr_q    <= '0;
      ch_blk_q   <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        ch_addr_q[i] <= '0;
        ch_cnt_q[i]  <= '0;
      end
      hrq_q      <= 1'b0;
      aen_q      <= 1'b0;
      adstb_q    <= 1'b0;
      dack_q     <= '0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      ior_q      <= 1'b0;
      iow_q      <= 1'b0;
      tc_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      last_q     <= last_d;
      mask_q     <= mask_d;
      ch_wr_q    <= ch_wr_d;
      ch_blk_q   <= ch_blk_d;
      ch_addr_q  <= ch_addr_d;
      ch_cnt_q   <= ch_cnt_d;
      hrq_q      <= hrq_d;
      aen_q      <= aen_d;
      adstb_q    <= adstb_d;
      dack_q     <= dack_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      ior_q      <= ior_d;
      iow_q      <= iow_d;
      tc_q       <= tc_d;
    end
  end

  assign HRQ      = hrq_q;
  assign AEN      = aen_q;
  assign ADSTB    = adstb_q;
  assign dack     = dack_q;
  assign memread  = memread_q;
  assign memwrite = memwrite_q;
  assign ior      = ior_q;
  assign iow      = iow_q;
  assign tc       = tc_q;
  assign mask     = mask_q;
  assign addr     = (state_q inside {S1, S2, S3, S4}) ? ch_addr_q[ch_q] : '0;

endmodule
